// File: rtl/sram_1rw_req_ctrl.sv
// sram_1rw_req_ctrl
//   Initiator-side controller for a single-port 1RW SRAM macro with a
//   1-cycle registered read. Requests arrive over valid/ready and are passed
//   combinationally to the macro port. Read data is captured the cycle it
//   appears, either bypassed straight to the response port or parked in a
//   2-entry FIFO when the consumer stalls.
//
//   Optional build macro: SRAM_CTRL_INIT_EN
//     defined   : after reset an INIT pass writes zero to every macro entry
//                 (one per cycle, DEPTH cycles) with busy=1, then goes IDLE.
//     undefined : no INIT pass, busy tied low, IDLE directly after reset.
//
//   Ports
//     clock, reset         sole clock, synchronous active-high reset
//     req_valid/req_ready  request handshake
//     req_write            1=write, 0=read
//     req_addr, req_wdata  request address / write data
//     resp_valid/ready     read response handshake
//     resp_rdata           read response data
//     RW0_en/wmode/addr/wdata  macro drive
//     RW0_rdata            macro read data (valid the cycle after a read)
//     busy                 high while initialising
module sram_1rw_req_ctrl #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 82
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              RW0_en,
  output logic              RW0_wmode,
  output logic [ADDR_W-1:0] RW0_addr,
  output logic [DATA_W-1:0] RW0_wdata,
  input  logic [DATA_W-1:0] RW0_rdata,
  output logic              busy
);

  if (DEPTH != (1 << ADDR_W)) begin : g_depth_check
    $error("sram_1rw_req_ctrl: DEPTH must equal 2**ADDR_W");
  end

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic              r_inflight;
  logic [DATA_W-1:0] r_fifo [2];
  logic              r_rd_ptr;
  logic              r_wr_ptr;
  logic [1:0]        r_count;

  logic              w_req_ready;
  logic              w_accept;
  logic              w_rd_accept;
  logic              w_push;
  logic              w_pop;
  logic [1:0]        w_occ;

`ifdef SRAM_CTRL_INIT_EN
  logic [ADDR_W-1:0] r_init_cnt;
  localparam state_t RESET_STATE = ST_INIT;
`else
  localparam state_t RESET_STATE = ST_IDLE;
`endif

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) r_state <= RESET_STATE;
    else       r_state <= w_state_nxt;
  end

  // FSM: next state
  always_comb begin
    w_state_nxt = r_state;
`ifdef SRAM_CTRL_INIT_EN
    if (r_state == ST_INIT && r_init_cnt == ADDR_W'(DEPTH - 1))
      w_state_nxt = ST_IDLE;
`endif
  end

`ifdef SRAM_CTRL_INIT_EN
  always_ff @(posedge clock) begin
    if (reset)                  r_init_cnt <= '0;
    else if (r_state == ST_INIT) r_init_cnt <= r_init_cnt + 1'b1;
  end
`endif

  // ---------------------------------------------------------------------
  // Credit: occupancy counts parked entries plus the read whose data lands
  // next cycle. Built only from registers so resp_ready never reaches
  // req_ready combinationally; a pop frees its credit one cycle later.
  // Outputs are forced to their reset values while reset is held.
  // ---------------------------------------------------------------------
  assign w_occ       = r_count + 2'(r_inflight);
  assign w_req_ready = !reset && (r_state == ST_IDLE) && (w_occ < 2'd2);
  assign w_accept    = req_valid && w_req_ready;
  assign w_rd_accept = w_accept && !req_write;

  // FSM: outputs (macro drive, handshake, busy)
  always_comb begin
    req_ready = w_req_ready;
    busy      = 1'b0;
    RW0_en    = 1'b0;
    RW0_wmode = 1'b0;
    RW0_addr  = '0;
    RW0_wdata = '0;
`ifdef SRAM_CTRL_INIT_EN
    if (reset) begin
      busy = 1'b1;
    end else if (r_state == ST_INIT) begin
      busy      = 1'b1;
      RW0_en    = 1'b1;
      RW0_wmode = 1'b1;
      RW0_addr  = r_init_cnt;
    end
`endif
    if (w_accept) begin
      RW0_en    = 1'b1;
      RW0_wmode = req_write;
      RW0_addr  = req_addr;
      RW0_wdata = req_wdata;
    end
  end

  // ---------------------------------------------------------------------
  // Response path. Macro data is only valid the cycle after the read, so it
  // is either handed out via bypass (FIFO empty and consumer ready) or
  // captured into the FIFO that same cycle. FIFO entries are older than the
  // inflight read, so the head always wins.
  // ---------------------------------------------------------------------
  assign w_push = r_inflight && !((r_count == 2'd0) && resp_ready);
  assign w_pop  = (r_count != 2'd0) && resp_ready;

  assign resp_valid = !reset && ((r_count != 2'd0) || r_inflight);
  assign resp_rdata = (r_count != 2'd0) ? r_fifo[r_rd_ptr] : RW0_rdata;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_inflight <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_wr_ptr   <= 1'b0;
      r_count    <= '0;
    end else begin
      r_inflight <= w_rd_accept;
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + 2'(w_push) - 2'(w_pop);
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) r_fifo[r_wr_ptr] <= RW0_rdata;
  end

endmodule

// File: tb/tb_sram_1rw_req_ctrl.sv
module tb_sram_1rw_req_ctrl;
  localparam int AW = 10;
  localparam int DW = 82;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          resp_valid;
  logic          resp_ready = 1'b0;
  logic [DW-1:0] resp_rdata;
  logic          RW0_en;
  logic          RW0_wmode;
  logic [AW-1:0] RW0_addr;
  logic [DW-1:0] RW0_wdata;
  logic [DW-1:0] RW0_rdata;
  logic          busy;

  int n_checks = 0;
  int n_fail   = 0;

  sram_1rw_req_ctrl #(.DEPTH(1024), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .RW0_en(RW0_en), .RW0_wmode(RW0_wmode), .RW0_addr(RW0_addr),
    .RW0_wdata(RW0_wdata), .RW0_rdata(RW0_rdata), .busy(busy)
  );

  always #5 clock = ~clock;

  // Macro model: registered read, output is garbage (all ones) on any cycle
  // not directly following a read, so late capture would be visible.
  logic [DW-1:0] mem [1024];
  logic [DW-1:0] rdq;
  logic          pl_en = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [DW-1:0] pl_data = '0;
  always @(posedge clock) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    if (RW0_en) begin
      if (RW0_wmode) mem[RW0_addr] <= RW0_wdata;
      rdq <= RW0_wmode ? '1 : mem[RW0_addr];
    end else begin
      rdq <= '1;
    end
  end
  assign RW0_rdata = rdq;

`ifdef SRAM_CTRL_INIT_EN
  localparam bit INIT_BUILD = 1'b1;
`else
  localparam bit INIT_BUILD = 1'b0;
`endif

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive inputs at the falling edge, then settle 1 time unit before checks.
  task automatic drv(input logic v, input logic w, input logic [AW-1:0] a,
                     input logic [DW-1:0] d, input logic rr);
    @(negedge clock);
    req_valid  = v;
    req_write  = w;
    req_addr   = a;
    req_wdata  = d;
    resp_ready = rr;
    #1;
  endtask

  task automatic wait_init_done(input string tag);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 3000) begin
      @(negedge clock); #1;
      n++;
    end
    chk(tag, busy, 1'b0);
  endtask

  logic [DW-1:0] shadow [1024];
  logic [DW-1:0] q [$];
  int            outstanding;
  logic [DW-1:0] d1;

  initial begin
    d1 = 82'h2_AAAA_5555_0000_FFFF_1;

    // ---------------- reset state ----------------
    if (INIT_BUILD) begin
      pl_en = 1'b1;
      pl_addr = 10'd0;   pl_data = 82'h1234_5678; @(posedge clock); #1;
      pl_addr = 10'd511; pl_data = 82'h3_0000_0000_0000_0000_0001; @(posedge clock); #1;
      pl_addr = 10'd1023; pl_data = 82'hDEAD_BEEF; @(posedge clock); #1;
      pl_en = 1'b0;
    end
    drv(1, 1, 10'h155, 82'h77, 0);
    reset = 1'b1;
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_en", RW0_en, 0);
    chk("rst_addr", RW0_addr, 0);
    chk("rst_wdata", RW0_wdata, 0);
    chk("rst_busy", busy, INIT_BUILD);
    drv(0, 0, 0, 0, 0);
    reset = 1'b0;
    #1;
    if (INIT_BUILD) begin
      int n;
      int rdy_seen;
      n = 0; rdy_seen = 0;
      while (busy === 1'b1 && n < 3000) begin
        if (req_ready !== 1'b0) rdy_seen++;
        @(negedge clock); #1;
        n++;
      end
      chk("init_cycles", n, 1024);
      chk("init_ready_low", rdy_seen, 0);
      drv(1, 0, 10'd0, 0, 1);
      drv(1, 0, 10'd511, 0, 1);
      chk("init_rd0", resp_rdata, 0);
      drv(1, 0, 10'd1023, 0, 1);
      chk("init_rd511", resp_rdata, 0);
      drv(0, 0, 0, 0, 1);
      chk("init_rd1023", resp_rdata, 0);
    end
    chk("post_rst_ready", req_ready, 1);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_resp_valid", resp_valid, 0);

    // ---------------- write then read same address ----------------
    drv(1, 1, 10'h3A5, d1, 1);
    chk("wr_en", RW0_en, 1);
    chk("wr_wmode", RW0_wmode, 1);
    chk("wr_addr", RW0_addr, 10'h3A5);
    chk("wr_wdata", RW0_wdata, d1);
    drv(1, 0, 10'h3A5, 0, 1);
    chk("rd_en", RW0_en, 1);
    chk("rd_wmode", RW0_wmode, 0);
    chk("rd_resp_early", resp_valid, 0);
    drv(0, 0, 0, 0, 1);
    chk("rd_resp_valid", resp_valid, 1);
    chk("rd_resp_data", resp_rdata, d1);
    chk("idle_en", RW0_en, 0);
    drv(0, 0, 0, 0, 1);
    chk("rd_resp_once", resp_valid, 0);

    // ---------------- backpressure / full / ordering ----------------
    for (int i = 0; i < 4; i++) drv(1, 1, AW'(i), DW'(32'h100 + i), 1);
    drv(1, 0, 10'd0, 0, 0);
    chk("bp_s1_ready", req_ready, 1);
    drv(1, 0, 10'd1, 0, 0);
    chk("bp_s2_ready", req_ready, 1);
    chk("bp_s2_valid", resp_valid, 1);
    chk("bp_s2_data", resp_rdata, 82'h100);
    drv(1, 0, 10'd2, 0, 0);
    chk("bp_s3_full", req_ready, 0);
    chk("bp_s3_data", resp_rdata, 82'h100);
    chk("bp_s3_en", RW0_en, 0);
    drv(1, 0, 10'd2, 0, 0);
    chk("bp_s4_full", req_ready, 0);
    drv(1, 0, 10'd2, 0, 1);
    chk("bp_s5_no_comb", req_ready, 0);
    chk("bp_s5_data", resp_rdata, 82'h100);
    drv(1, 0, 10'd2, 0, 1);
    chk("bp_s6_ready", req_ready, 1);
    chk("bp_s6_data", resp_rdata, 82'h101);
    drv(1, 0, 10'd3, 0, 1);
    chk("bp_s7_ready", req_ready, 1);
    chk("bp_s7_data", resp_rdata, 82'h102);
    drv(0, 0, 0, 0, 1);
    chk("bp_s8_valid", resp_valid, 1);
    chk("bp_s8_data", resp_rdata, 82'h103);
    drv(0, 0, 0, 0, 1);
    chk("bp_s9_empty", resp_valid, 0);

    // ---------------- write after read hazard ----------------
    drv(1, 1, 10'd5, 82'h11, 1);
    drv(1, 0, 10'd5, 0, 0);
    drv(1, 1, 10'd5, 82'h22, 0);
    chk("war_ready", req_ready, 1);
    chk("war_s2_data", resp_rdata, 82'h11);
    drv(0, 0, 0, 0, 0);
    chk("war_s3_data", resp_rdata, 82'h11);
    drv(0, 0, 0, 0, 1);
    chk("war_s4_valid", resp_valid, 1);
    chk("war_s4_data", resp_rdata, 82'h11);
    drv(1, 0, 10'd5, 0, 1);
    chk("war_s5_empty", resp_valid, 0);
    drv(0, 0, 0, 0, 1);
    chk("war_new_data", resp_rdata, 82'h22);

    // ---------------- reset mid-operation ----------------
    drv(1, 0, 10'd0, 0, 0);
    drv(1, 0, 10'd1, 0, 0);
    drv(1, 1, 10'h3FF, 82'h55, 0);
    reset = 1'b1;
    #1;
    chk("mid_rst_ready", req_ready, 0);
    chk("mid_rst_valid", resp_valid, 0);
    chk("mid_rst_en", RW0_en, 0);
    chk("mid_rst_wmode", RW0_wmode, 0);
    chk("mid_rst_addr", RW0_addr, 0);
    chk("mid_rst_wdata", RW0_wdata, 0);
    drv(0, 0, 0, 0, 1);
    reset = 1'b0;
    #1;
    chk("mid_post_valid", resp_valid, 0);
    drv(0, 0, 0, 0, 1);
    chk("mid_post_valid2", resp_valid, 0);
    if (INIT_BUILD) wait_init_done("mid_init_done");
    chk("mid_post_ready", req_ready, 1);

    // ---------------- random mix against scoreboard ----------------
    shadow = mem;
    outstanding = 0;
    for (int c = 0; c < 4000; c++) begin
      logic v, w, rr;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      v  = ($urandom_range(0, 3) != 0);
      w  = ($urandom_range(0, 2) == 0);
      rr = ($urandom_range(0, 3) != 0);
      a  = AW'($urandom_range(0, 7));
      d  = DW'({$urandom(), $urandom(), $urandom()});
      drv(v, w, a, d, rr);
      chk("rnd_valid", resp_valid, outstanding != 0);
      chk("rnd_ready", req_ready, outstanding < 2);
      if (resp_valid && resp_ready) begin
        chk("rnd_nonempty", q.size() != 0, 1);
        if (q.size() != 0) chk("rnd_data", resp_rdata, q.pop_front());
        outstanding--;
      end
      if (req_valid && req_ready) begin
        if (w) shadow[a] = d;
        else begin
          q.push_back(shadow[a]);
          outstanding++;
        end
      end
      chk("rnd_outstanding", outstanding <= 2, 1);
    end
    begin
      int n;
      n = 0;
      while (q.size() != 0 && n < 50) begin
        drv(0, 0, 0, 0, 1);
        if (resp_valid) chk("drain_data", resp_rdata, q.pop_front());
        n++;
      end
      chk("drain_done", q.size(), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
